servo_avalon_multi: RTL and testbench
=====================================

// Module: servo_avalon_multi
// PURPOSE
//  Multi-channel servo controller on an Avalon-MM slave: CHANNELS independent PWM outputs sharing one period
//  counter, plus per-channel feedback pulse-width capture. Successor to the single-channel servo block.
//  Width updates are glitch-free because they apply at the period boundary. Sits on the HPS/Nios bus like other servo peripherals.
// PARAMETERS
//  CHANNELS     4        number of servo channels (1..8)
//  CNT_W        21       width of the period, pulse-width and capture counters
//  ADDR_W       4        word-address width; 2**ADDR_W >= 2+2*CHANNELS
//  DEF_PERIOD   1000000  period reset value in clocks (20 ms at 50 MHz)
//  DEF_WIDTH    75000    per-channel pulse-width reset value (1.5 ms at 50 MHz)
// PORTS
//  clock_clk     in   1         system clock
//  reset_low     in   1         asynchronous active-low reset
//  cs            in   1         chip select
//  read          in   1         read strobe (qualified by cs)
//  write         in   1         write strobe (qualified by cs)
//  address       in   ADDR_W    word address
//  writedata     in   32        write data
//  readdata      out  32        registered read data
//  pwm_response  in   CHANNELS  feedback pulses from servos (asynchronous)
//  pwm_out       out  CHANNELS  PWM drive outputs
// BEHAVIOUR
//  Register map (word addresses):
//   0 CTRL: bits [CHANNELS-1:0] are per-channel enables, reset 0. Other bits read 0.
//   1 PERIOD: [CNT_W-1:0], reset DEF_PERIOD. A written value below 2 is stored as 2.
//   2+2k WIDTH[k]: [CNT_W-1:0], reset DEF_WIDTH.
//   3+2k FB[k], read-only: bit31 NEW flag, [CNT_W-1:0] last captured high time. Reset 0.
//   Unmapped reads return 0. Writes to read-only or unmapped addresses are ignored.
//  Bus:
//   - Reads and writes take effect only when cs=1. If read and write are both high, read has priority (write dropped).
//   - readdata is updated one cycle after cs&read and holds its value otherwise. Reset value 0.
//  PWM:
//   - A shared counter cnt runs 0..period_act-1 and then wraps to 0.
//   - On the wrap cycle (cnt==period_act-1), period_act<=PERIOD and wshadow[k]<=WIDTH[k].
//     Register writes never change the current period mid-cycle.
//   - After reset, period_act=DEF_PERIOD and wshadow=DEF_WIDTH.
//   - pwm_out[k] is registered: pwm_out[k] = CTRL[k] && (cnt < wshadow[k]).
//     WIDTH 0 gives constant low. WIDTH >= period gives constant high.
//   - Clearing an enable drives the output low on the next clock. Setting it takes effect immediately, mid-period.
//   - pwm_out resets to 0.
//  Feedback, per channel:
//   - pwm_response[k] passes through a 2-FF synchroniser, then an edge detector.
//   - Rising edge: clear the high-time counter. While high: increment, saturating at all-ones.
//   - Falling edge: FB[k].width<=counter and NEW<=1.
//   - A read of FB[k] clears NEW on the same cycle. If a capture coincides with that read,
//     readdata shows the old value and NEW stays 1.
//   - Feedback capture runs whether or not the channel is enabled.
//  Reset mid-operation: all registers and counters return to reset values asynchronously.
//   Outputs are low until reset is released; the first period then starts at cnt=0.
// TESTING
//  1. After reset: read PERIOD -> 1000000, WIDTH0 -> 75000, CTRL -> 0, pwm_out == 0.
//  2. PERIOD=100, WIDTH0=30, CTRL=1. After the next wrap, pwm_out[0] is high for 30 clocks and low for 70,
//     repeating every 100 clocks.
//  3. Mid-period, write WIDTH0=60 -> the current pulse stays 30; the next pulse is 60 clocks. No runt pulse.
//  4. WIDTH1=0 gives constant low. WIDTH1=100 with PERIOD=100 gives constant high. Writing PERIOD=1 reads back 2.
//  5. Drive pwm_response[2] high for 500 clocks -> FB2 reads 0x800001F4 (allowing for sync delay).
//     A second read returns 0x000001F4.
//  6. Assert reset_low=0 mid-pulse -> pwm_out drops to 0 immediately. After release, test 1 values are restored.

Source files
------------

// File: rtl/servo_avalon_multi.sv
// Multi-channel servo PWM controller with an Avalon-MM slave interface.
// All channels share one period counter. Each channel has a pulse width
// that is shadowed at the period boundary, plus a feedback pulse-width capture.
module servo_avalon_multi #(
    parameter int CHANNELS   = 4,
    parameter int CNT_W      = 21,
    parameter int ADDR_W     = 4,
    parameter int DEF_PERIOD = 1000000,
    parameter int DEF_WIDTH  = 75000
) (
    input  logic                clock_clk,
    input  logic                reset_low,
    input  logic                cs,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [CHANNELS-1:0] pwm_response,
    output logic [CHANNELS-1:0] pwm_out
);

    localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_W   = CNT_W'(DEF_WIDTH);
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALL_ONE = '1;

    logic                rd_en;
    logic                wr_en;
    logic [CNT_W-1:0]    wdata_cnt;
    logic [31:0]         rd_mux;
    logic [CHANNELS-1:0] fb_rd;

    logic [CHANNELS-1:0] ctrl;
    logic [CNT_W-1:0]    period;
    logic [CNT_W-1:0]    width    [CHANNELS];

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    period_act;
    logic [CNT_W-1:0]    wshadow  [CHANNELS];
    logic                wrap;

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] sync_prev;
    logic [CNT_W-1:0]    hcnt     [CHANNELS];
    logic [CNT_W-1:0]    fb_width [CHANNELS];
    logic [CHANNELS-1:0] fb_new;

    // Upper write-data bits beyond the counter width have no destination.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata[31:CNT_W]};

    // Read wins over write when both strobes are high.
    assign rd_en     = cs & read;
    assign wr_en     = cs & write & ~read;
    assign wdata_cnt = writedata[CNT_W-1:0];
    assign wrap      = (cnt == period_act - ONE);

    // Configuration registers; a too-short period is clamped so cnt always wraps.
    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            ctrl   <= '0;
            period <= DEF_P;
            for (int k = 0; k < CHANNELS; k++) width[k] <= DEF_W;
        end else if (wr_en) begin
            if (address == ADDR_W'(0)) ctrl <= writedata[CHANNELS-1:0];
            if (address == ADDR_W'(1)) period <= (wdata_cnt < MIN_P) ? MIN_P : wdata_cnt;
            for (int k = 0; k < CHANNELS; k++) begin
                if (address == ADDR_W'(2 + 2*k)) width[k] <= wdata_cnt;
            end
        end
    end

    // Read data selection and per-channel FB read strobes.
    always_comb begin
        rd_mux = '0;
        fb_rd  = '0;
        if (address == ADDR_W'(0)) rd_mux[CHANNELS-1:0] = ctrl;
        if (address == ADDR_W'(1)) rd_mux[CNT_W-1:0] = period;
        for (int k = 0; k < CHANNELS; k++) begin
            if (address == ADDR_W'(2 + 2*k)) rd_mux[CNT_W-1:0] = width[k];
            if (address == ADDR_W'(3 + 2*k)) begin
                rd_mux[CNT_W-1:0] = fb_width[k];
                rd_mux[31]        = fb_new[k];
                fb_rd[k]          = rd_en;
            end
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) readdata <= '0;
        else if (rd_en) readdata <= rd_mux;
    end

    // Shared period counter; period and widths are reloaded only on the wrap cycle.
    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            cnt        <= '0;
            period_act <= DEF_P;
            for (int k = 0; k < CHANNELS; k++) wshadow[k] <= DEF_W;
        end else if (wrap) begin
            cnt        <= '0;
            period_act <= period;
            for (int k = 0; k < CHANNELS; k++) wshadow[k] <= width[k];
        end else begin
            cnt <= cnt + ONE;
        end
    end

    // Registered PWM compare, gated by the live enable bits.
    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            pwm_out <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) pwm_out[k] <= ctrl[k] && (cnt < wshadow[k]);
        end
    end

    // Feedback synchroniser plus edge history.
    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
        end else begin
            sync1     <= pwm_response;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // High-time measurement and capture. The rising-edge cycle is itself the
    // first high cycle, so the counter restarts at 1 rather than 0.
    // A capture in the same cycle as an FB read keeps NEW set.
    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            fb_new <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                hcnt[k]     <= '0;
                fb_width[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (sync2[k] && !sync_prev[k]) hcnt[k] <= ONE;
                else if (sync2[k] && hcnt[k] != ALL_ONE) hcnt[k] <= hcnt[k] + ONE;

                if (!sync2[k] && sync_prev[k]) begin
                    fb_width[k] <= hcnt[k];
                    fb_new[k]   <= 1'b1;
                end else if (fb_rd[k]) begin
                    fb_new[k]   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_avalon_multi.sv
// Self-checking bench for servo_avalon_multi. Read results go through a
// scoreboard queue; PWM shape is checked by measuring pulse lengths.
// The reset period/width are scaled down so the first wrap comes quickly.
module tb_servo_avalon_multi;
    localparam int CH = 4;
    localparam int CW = 21;
    localparam int AW = 4;
    localparam int DP = 1000;
    localparam int DW = 75;

    logic          clock_clk = 1'b0;
    logic          reset_low = 1'b0;
    logic          cs = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] address = '0;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [CH-1:0] pwm_response = '0;
    logic [CH-1:0] pwm_out;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_seen = 1'b0;

    servo_avalon_multi #(
        .CHANNELS(CH), .CNT_W(CW), .ADDR_W(AW), .DEF_PERIOD(DP), .DEF_WIDTH(DW)
    ) dut (
        .clock_clk(clock_clk), .reset_low(reset_low), .cs(cs), .read(read),
        .write(write), .address(address), .writedata(writedata),
        .readdata(readdata), .pwm_response(pwm_response), .pwm_out(pwm_out)
    );

    always #5 clock_clk = ~clock_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a read strobe seen at a rising edge yields readdata by the next falling edge.
    always @(posedge clock_clk) rd_seen <= cs & read;

    always @(negedge clock_clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            else chk(tag_q.pop_front(), readdata, exp_q.pop_front());
        end
    end

    task automatic bus_read(input int addr, input logic [31:0] exp, input string tag);
        @(negedge clock_clk);
        cs = 1'b1; read = 1'b1; address = AW'(addr);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clock_clk);
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic bus_write(input int addr, input logic [31:0] data, input logic sel = 1'b1);
        @(negedge clock_clk);
        cs = sel; write = 1'b1; address = AW'(addr); writedata = data;
        @(negedge clock_clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read_write(input int addr, input logic [31:0] data, input logic [31:0] exp, input string tag);
        @(negedge clock_clk);
        cs = 1'b1; read = 1'b1; write = 1'b1; address = AW'(addr); writedata = data;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clock_clk);
        cs = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic wait_rise(input string tag);
        logic prev;
        logic found;
        prev  = pwm_out[0];
        found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            @(negedge clock_clk);
            if (pwm_out[0] && !prev) found = 1'b1;
            prev = pwm_out[0];
        end
        if (!found) chk(tag, 32'(found), 32'd1);
    endtask

    // Starts on the falling edge where pwm_out[0] first reads high; ends on the next such edge.
    task automatic measure(output int hi, output int lo);
        logic busy;
        hi = 1; lo = 0; busy = 1'b1;
        for (int n = 0; n < 3000 && busy; n++) begin
            @(negedge clock_clk);
            if (pwm_out[0]) hi++;
            else busy = 1'b0;
        end
        lo = 1; busy = 1'b1;
        for (int n = 0; n < 3000 && busy; n++) begin
            @(negedge clock_clk);
            if (!pwm_out[0]) lo++;
            else busy = 1'b0;
        end
    endtask

    task automatic count_high(input int ch, input int cycles, output int c);
        c = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clock_clk);
            if (pwm_out[ch]) c++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, lo, hi2, lo2, c;

        repeat (3) @(negedge clock_clk);
        reset_low = 1'b1;
        @(negedge clock_clk);

        // Reset state
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        bus_read(1, DP, "rst_period");
        bus_read(2, DW, "rst_width0");
        bus_read(0, 0, "rst_ctrl");
        bus_read(7, 0, "rst_fb2");
        bus_read(5, 0, "rst_fb1");

        // Basic PWM: period 100, width 30
        bus_write(1, 100);
        bus_write(2, 30);
        bus_write(0, 1);
        bus_read(0, 1, "ctrl_rb");
        repeat (1100) @(negedge clock_clk);
        wait_rise("t2_rise_timeout");
        measure(hi, lo);
        chk("t2_hi_a", hi, 30);
        chk("t2_lo_a", lo, 70);
        measure(hi, lo);
        chk("t2_hi_b", hi, 30);
        chk("t2_lo_b", lo, 70);

        // Mid-pulse width change applies only from the next period
        fork
            begin
                measure(hi, lo);
                measure(hi2, lo2);
            end
            begin
                repeat (10) @(negedge clock_clk);
                bus_write(2, 60);
            end
        join
        chk("t3_cur_hi", hi, 30);
        chk("t3_cur_lo", lo, 70);
        chk("t3_next_hi", hi2, 60);
        chk("t3_next_lo", lo2, 40);

        // Width boundaries on channel 1
        bus_write(4, 0);
        bus_write(0, 3);
        repeat (150) @(negedge clock_clk);
        count_high(1, 100, c);
        chk("t4_width0_low", c, 0);
        bus_write(4, 100);
        repeat (150) @(negedge clock_clk);
        count_high(1, 100, c);
        chk("t4_width_full_high", c, 100);
        count_high(0, 100, c);
        chk("t4_ch0_duty", c, 60);

        // Bus corner cases
        bus_read_write(2, 32'd5, 32'd60, "rw_read_wins");
        bus_read(2, 60, "rw_write_dropped");
        bus_write(2, 32'd7, 1'b0);
        bus_read(2, 60, "nocs_write_ignored");
        bus_write(7, 32'h1234);
        bus_read(7, 0, "fb_ro_write_ignored");
        bus_read(12, 0, "unmapped_read");
        bus_write(1, 1);
        bus_read(1, 2, "t4_period_clamp");

        // Feedback capture on channel 2 (channel disabled)
        @(negedge clock_clk);
        pwm_response[2] = 1'b1;
        repeat (500) @(negedge clock_clk);
        pwm_response[2] = 1'b0;
        repeat (6) @(negedge clock_clk);
        bus_read(7, 32'h8000_01F4, "t5_fb2_new");
        bus_read(7, 32'h0000_01F4, "t5_fb2_cleared");
        bus_read(3, 0, "t5_fb0_idle");

        // Reset in the middle of a pulse
        bus_write(1, 100);
        bus_write(2, 30);
        bus_write(0, 1);
        repeat (10) @(negedge clock_clk);
        wait_rise("t6_rise_timeout");
        repeat (5) @(negedge clock_clk);
        chk("t6_mid_pulse", 32'(pwm_out[0]), 32'd1);
        reset_low = 1'b0;
        #1;
        chk("t6_rst_pwm_async", 32'(pwm_out), 32'd0);
        repeat (3) @(negedge clock_clk);
        chk("t6_rst_readdata", readdata, 32'd0);
        reset_low = 1'b1;
        bus_read(1, DP, "t6_period");
        bus_read(2, DW, "t6_width0");
        bus_read(0, 0, "t6_ctrl");
        bus_read(7, 0, "t6_fb2");
        chk("t6_pwm_after", 32'(pwm_out), 32'd0);

        repeat (3) @(negedge clock_clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
